// File: rtl/wb_pkg.sv
// Shared types for the standard-to-pipelined Wishbone bridge and its RAM slave.
package wb_pkg;

   localparam int unsigned ADR_WIDTH     = 16;
   localparam int unsigned DAT_WIDTH     = 16;
   localparam int unsigned RAM_ADR_WIDTH = 8;
   localparam int unsigned RAM_DEPTH     = 1 << RAM_ADR_WIDTH;

   typedef logic [ADR_WIDTH-1:0]     adr_t;
   typedef logic [DAT_WIDTH-1:0]     dat_t;
   typedef logic [RAM_ADR_WIDTH-1:0] ram_adr_t;

   typedef enum logic {IDLE, WAIT} bridge_state_t;

   // Master-to-slave payload of the internal pipelined bus.
   typedef struct packed {
      logic cyc;
      logic stb;
      logic we;
      adr_t adr;
      dat_t dat;
   } wb_req_t;

   // Slave-to-master payload of the internal pipelined bus.
   typedef struct packed {
      logic stall;
      logic ack;
      dat_t dat;
   } wb_rsp_t;

endpackage

// File: rtl/wb_pipelined_ram.sv
// Pipelined Wishbone RAM slave: registered ack/read data one cycle after acceptance.
// Define WB_STALL_INJECT_EN to stall the first cycle of every new request.
module wb_pipelined_ram
   import wb_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  wb_req_t req_i,
   output wb_rsp_t rsp_o
);

   dat_t     mem_q [RAM_DEPTH];
   logic     ack_q;
   dat_t     dat_q;
   logic     stall;
   logic     accept;
   ram_adr_t idx;
   logic     unused_adr_hi;

   // Upper address bits alias onto the RAM depth.
   assign idx           = req_i.adr[RAM_ADR_WIDTH-1:0];
   assign unused_adr_hi = ^req_i.adr[ADR_WIDTH-1:RAM_ADR_WIDTH];

`ifdef WB_STALL_INJECT_EN
   logic stalled_q;

   // Stall exactly once per request: released after one stalled cycle.
   assign stall = req_i.cyc & req_i.stb & ~stalled_q;

   always_ff @(posedge clk) begin
      if (rst) stalled_q <= 1'b0;
      else     stalled_q <= stall;
   end
`else
   assign stall = 1'b0;
`endif

   assign accept = req_i.cyc & req_i.stb & ~stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= accept;
         if (accept && !req_i.we) dat_q <= mem_q[idx];
      end
   end

   // Storage is not reset; a write coinciding with reset is suppressed.
   always_ff @(posedge clk) begin
      if (accept && req_i.we && !rst) mem_q[idx] <= req_i.dat;
   end

   assign rsp_o.stall = stall;
   assign rsp_o.ack   = ack_q;
   assign rsp_o.dat   = dat_q;

endmodule

// File: rtl/wb_std_to_pipelined_ram.sv
// Standard (classic) Wishbone slave bridging each cycle to one pipelined request on a RAM.
// Optional WB_STALL_INJECT_EN adds one stall cycle per transfer inside the RAM.
module wb_std_to_pipelined_ram
   import wb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [ADR_WIDTH-1:0] wb_adr_i,
   input  logic [DAT_WIDTH-1:0] wb_dat_m_i,
   output logic [DAT_WIDTH-1:0] wb_dat_s_o,
   output logic                 wb_ack_o
);

   bridge_state_t state_q;
   wb_req_t       wb2_req;
   wb_rsp_t       wb2_rsp;

   // Only issue a request from IDLE so a held strobe never reissues.
   always_comb begin
      wb2_req.cyc = wb_cyc_i;
      wb2_req.stb = wb_cyc_i & wb_stb_i & (state_q == IDLE);
      wb2_req.we  = wb_we_i;
      wb2_req.adr = wb_adr_i;
      wb2_req.dat = wb_dat_m_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (wb2_req.stb && !wb2_rsp.stall) state_q <= WAIT;
            WAIT:    if (!wb_cyc_i || wb2_rsp.ack)      state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // An ack arriving after the master abandoned the cycle is swallowed.
   assign wb_ack_o   = wb2_rsp.ack & wb_cyc_i & wb_stb_i;
   assign wb_dat_s_o = wb2_rsp.dat;

   wb_pipelined_ram u_ram (
      .clk   (clk),
      .rst   (rst),
      .req_i (wb2_req),
      .rsp_o (wb2_rsp)
   );

endmodule

// File: tb/tb_wb_std_to_pipelined_ram.sv
// Self-checking bench: vector table, corner-case sequences and random traffic vs a RAM model.
module tb_wb_std_to_pipelined_ram;

`ifdef WB_STALL_INJECT_EN
   localparam int EXP_LAT = 2;
`else
   localparam int EXP_LAT = 1;
`endif
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [15:0] adr = '0;
   logic [15:0] dat_m = '0;
   logic [15:0] dat_s;
   logic        ack;

   int tests = 0;
   int fails = 0;

   logic [15:0] model [256];

   typedef struct {
      bit          we;
      logic [15:0] adr;
      logic [15:0] dat;
      bit          gap;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   wb_std_to_pipelined_ram dut (
      .clk        (clk),
      .rst        (rst),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_adr_i   (adr),
      .wb_dat_m_i (dat_m),
      .wb_dat_s_o (dat_s),
      .wb_ack_o   (ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One classic cycle; entered just after a rising edge, leaves just after one.
   task automatic run(input bit w, input logic [15:0] a, input logic [15:0] d, input bit gap,
                      output logic [15:0] rdat);
      int lat;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_m = d;
      lat = 0;
      rdat = 'x;
      forever begin
         @(negedge clk);
         if (ack) break;
         lat++;
         if (lat > TIMEOUT) break;
         @(posedge clk); #1;
      end
      check("ack_latency", 32'(lat), 32'(EXP_LAT));
      rdat = dat_s;
      if (w && lat <= TIMEOUT) model[a[7:0]] = d;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      if (gap) begin
         @(negedge clk);
         check("idle_no_ack", 32'(ack), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [15:0] r;
      logic [15:0] wq[$];

      // Reset for 3 clocks, then confirm quiet outputs.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("reset_ack", 32'(ack), 32'd0);
         check("reset_dat", 32'(dat_s), 32'd0);
      end
      @(posedge clk); #1;

      for (int i = 1; i <= 10; i++) vecs.push_back('{1'b1, 16'(i), 16'(100 + i), 1'b1});
      for (int i = 1; i <= 10; i++) vecs.push_back('{1'b0, 16'(i), 16'(100 + i), 1'b0});
      for (int i = 11; i <= 20; i++) vecs.push_back('{1'b1, 16'(i), 16'(200 + i), 1'b0});
      for (int i = 11; i <= 20; i++) vecs.push_back('{1'b0, 16'(i), 16'(200 + i), 1'b0});
      vecs.push_back('{1'b1, 16'h0105, 16'h0AAA, 1'b0});
      vecs.push_back('{1'b0, 16'h0005, 16'h0AAA, 1'b1});
      vecs.push_back('{1'b1, 16'hFFFF, 16'h5A5A, 1'b0});
      vecs.push_back('{1'b0, 16'h00FF, 16'h5A5A, 1'b0});

      foreach (vecs[i]) begin
         run(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].gap, r);
         if (!vecs[i].we) check($sformatf("vec%0d_rdat", i), 32'(r), 32'(vecs[i].dat));
      end

      // Abandon a read once it is in flight: no ack may reach the master.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd2;
      repeat (EXP_LAT) @(posedge clk);
      #1 cyc = 1'b0; stb = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("drop_cyc_no_ack", 32'(ack), 32'd0);
      end
      @(posedge clk); #1;
      run(1'b0, 16'd1, 16'd0, 1'b0, r);
      check("after_drop_rdat", 32'(r), 32'd101);

      // Reset asserted at the accepting edge must suppress the write.
      run(1'b1, 16'd30, 16'd777, 1'b1, r);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd30; dat_m = 16'd555; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("midreset_ack", 32'(ack), 32'd0);
      @(posedge clk); #1;
      run(1'b0, 16'd30, 16'd0, 1'b0, r);
      check("midreset_no_write", 32'(r), 32'd777);

      // Random traffic against the model; reads only hit locations already written.
      for (int i = 0; i < 150; i++) begin
         logic [15:0] a, d, hi;
         bit w;
         w  = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
         d  = 16'($urandom);
         hi = 16'($urandom);
         if (w) begin
            a = 16'($urandom);
            wq.push_back(a);
         end else begin
            a = wq[$urandom_range(0, wq.size() - 1)];
            a = {hi[7:0], a[7:0]};
         end
         run(w, a, d, $urandom_range(0, 1) == 1, r);
         if (!w) check($sformatf("rand%0d_rdat", i), 32'(r), 32'(model[a[7:0]]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
